// File: rtl/router_out_arbiter.sv
// ---------------------------------------------------------------------------
// router_out_arbiter
//
// Output-port arbiter for a wormhole router. Up to NPORT input ports compete
// for this output. A round-robin search picks one winner, which then holds
// the output until it has sent its tail flit. Flits only cross when the
// downstream buffer has room, which is tracked with a credit counter.
//
// Ports
//   clk         single clock, all state on the rising edge
//   RST_        asynchronous active-low reset; release is synchronised to clk
//   REQ         bit i: input port i has a head flit for this output
//   VALID       bit i: input port i presents a valid flit this cycle
//   TAIL        bit i: the flit presented by port i is the packet tail
//   CRED_RET    one downstream credit returned this cycle
//   GNT         one-hot grant (registered)
//   SEL         binary index of the granted port, for the crossbar mux
//               (registered; holds its last value while idle)
//   FIRE        a flit crosses to the output this cycle (combinational)
//   LOCKED      output held by a packet (registered)
//   CREDIT_CNT  available downstream credits (registered)
// ---------------------------------------------------------------------------
module router_out_arbiter #(
    parameter int NPORT   = 5,   // number of requesting input ports
    parameter int CREDITS = 4    // downstream buffer depth in flits, 1..7
) (
    input  logic             clk,
    input  logic             RST_,
    input  logic [NPORT-1:0] REQ,
    input  logic [NPORT-1:0] VALID,
    input  logic [NPORT-1:0] TAIL,
    input  logic             CRED_RET,
    output logic [NPORT-1:0] GNT,
    output logic [2:0]       SEL,
    output logic             FIRE,
    output logic             LOCKED,
    output logic [2:0]       CREDIT_CNT
);

    localparam logic [2:0] CRED_MAX  = 3'(CREDITS);
    // After reset the pointer sits on the last port so port 0 wins first.
    localparam logic [2:0] PTR_RESET = 3'(NPORT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [NPORT-1:0] gnt_q, gnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       credit_q, credit_d;
    logic             run_q;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [2:0]       cand;
    logic             fire;

    // -----------------------------------------------------------------------
    // Reset release. run_q is cleared asynchronously with everything else
    // but only rises on the first clock edge after RST_ goes high. Arbitration
    // is blocked until then, so the earliest grant lands on the second edge
    // and no grant can race the reset release.
    // -----------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment so that all
    // flops sample their inputs at the same instant of the clock edge.
    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin winner: first set REQ bit searched cyclically starting at
    // (ptr + 1) mod NPORT. Because ptr is loaded with the last winner, that
    // port drops to the lowest priority for the next search.
    // -----------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NPORT; i++) begin
            cand = 3'((int'(ptr_q) + 1 + i) % NPORT);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and outputs.
    //   IDLE: grant the round-robin winner if a credit is available.
    //   LOCK: forward flits of the granted port only; leave on the tail.
    // Leaving LOCK always passes through one IDLE cycle, so two grants never
    // occur on back-to-back edges.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        fire    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run_q && win_found && (credit_q != 3'd0)) begin
                    state_d        = LOCK;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    sel_d          = win_idx;
                end
            end

            LOCK: begin
                // A credit returned in this same cycle only counts from the
                // next cycle on, so FIRE looks at the registered count.
                fire = VALID[sel_q] && (credit_q != 3'd0);
                // REQ of the granted port is not consulted here: the packet
                // keeps the output until its tail even if REQ drops.
                if (fire && TAIL[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Credit counter. FIRE consumes one, CRED_RET returns one; both together
    // cancel. A return while already full is dropped. FIRE is only possible
    // with a non-zero count, so the decrement cannot underflow.
    // -----------------------------------------------------------------------
    always_comb begin
        credit_d = credit_q;
        unique case ({fire, CRED_RET})
            2'b10: credit_d = credit_q - 3'd1;
            2'b01: begin
                if (credit_q != CRED_MAX) begin
                    credit_d = credit_q + 3'd1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers. Reset drops any packet in flight immediately; since
    // FIRE is decoded from the LOCK state it goes low with the reset too.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            sel_q    <= '0;
            ptr_q    <= PTR_RESET;
            credit_q <= CRED_MAX;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    assign GNT        = gnt_q;
    assign SEL        = sel_q;
    assign FIRE       = fire;
    assign LOCKED     = (state_q == LOCK);
    assign CREDIT_CNT = credit_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_router_out_arbiter
//
// Directed self-checking bench for router_out_arbiter (NPORT=5, CREDITS=4).
// Inputs change 1 ns after a rising edge; outputs are compared before the
// next rising edge. Expected values are written out by hand per scenario.
// ---------------------------------------------------------------------------
module tb_router_out_arbiter;

    logic       clk;
    logic       rst_b;
    logic [4:0] req;
    logic [4:0] valid;
    logic [4:0] tail;
    logic       cred_ret;
    logic [4:0] gnt;
    logic [2:0] sel;
    logic       fire;
    logic       locked;
    logic [2:0] credit_cnt;

    int checks = 0;
    int errors = 0;

    router_out_arbiter #(
        .NPORT   (5),
        .CREDITS (4)
    ) dut (
        .clk        (clk),
        .RST_       (rst_b),
        .REQ        (req),
        .VALID      (valid),
        .TAIL       (tail),
        .CRED_RET   (cred_ret),
        .GNT        (gnt),
        .SEL        (sel),
        .FIRE       (fire),
        .LOCKED     (locked),
        .CREDIT_CNT (credit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req      = '0;
        valid    = '0;
        tail     = '0;
        cred_ret = 1'b0;
    endtask

    // Assert reset, then release it 1 ns after a rising edge.
    task automatic do_reset();
        idle_inputs();
        rst_b = 1'b0;
        cyc();
        rst_b = 1'b1;
    endtask

    initial begin
        int order [6] = '{0, 1, 2, 3, 4, 0};

        // ---------------- reset values, grant latency, single packet ------
        idle_inputs();
        rst_b = 1'b0;
        cyc();
        check("rst_gnt",    32'(gnt),        32'h0);
        check("rst_sel",    32'(sel),        32'h0);
        check("rst_locked", 32'(locked),     32'h0);
        check("rst_credit", 32'(credit_cnt), 32'h4);
        check("rst_fire",   32'(fire),       32'h0);

        rst_b = 1'b1;
        req   = 5'b00100;
        cyc();  // first edge after release: no grant yet
        check("rel_edge1_locked", 32'(locked), 32'h0);
        check("rel_edge1_gnt",    32'(gnt),    32'h0);
        cyc();  // second edge: port 2 granted
        check("first_gnt",    32'(gnt),        32'h04);
        check("first_sel",    32'(sel),        32'h2);
        check("first_locked", 32'(locked),     32'h1);
        check("first_credit", 32'(credit_cnt), 32'h4);
        check("first_fire_novalid", 32'(fire), 32'h0);

        valid = 5'b11011;
        tail  = 5'b11011;
        #1;
        check("other_valid_ignored", 32'(fire), 32'h0);
        valid = 5'b00100;
        tail  = 5'b00100;
        #1;
        check("single_flit_fire", 32'(fire), 32'h1);
        cyc();  // tail fired: back to IDLE
        idle_inputs();
        #1;
        check("after_tail_gnt",    32'(gnt),        32'h0);
        check("after_tail_locked", 32'(locked),     32'h0);
        check("idle_sel_holds",    32'(sel),        32'h2);
        check("after_tail_credit", 32'(credit_cnt), 32'h3);
        check("idle_fire",         32'(fire),       32'h0);
        cred_ret = 1'b1;
        cyc();
        check("cred_ret_inc", 32'(credit_cnt), 32'h4);
        cyc();
        check("cred_ret_saturate", 32'(credit_cnt), 32'h4);
        cred_ret = 1'b0;

        // ---------------- round-robin with all ports requesting -----------
        do_reset();
        cyc();
        req      = 5'b11111;
        valid    = 5'b11111;
        tail     = 5'b11111;
        cred_ret = 1'b1;  // keeps credits at 4 (fire+ret cancel, idle saturates)
        for (int k = 0; k < 6; k++) begin
            cyc();
            check($sformatf("rr%0d_gnt", k),    32'(gnt),        32'h1 << order[k]);
            check($sformatf("rr%0d_sel", k),    32'(sel),        32'(order[k]));
            check($sformatf("rr%0d_fire", k),   32'(fire),       32'h1);
            check($sformatf("rr%0d_credit", k), 32'(credit_cnt), 32'h4);
            cyc();
            check($sformatf("rr%0d_idle_gap", k), 32'(locked), 32'h0);
        end
        idle_inputs();

        // ---------------- packet lock against a competing request ---------
        do_reset();
        cyc();
        req = 5'b00010;
        cyc();
        check("pl_gnt_p1", 32'(gnt), 32'h02);
        req   = 5'b01010;
        valid = 5'b01010;
        tail  = 5'b01000;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) tail = 5'b01010;
            #1;
            check($sformatf("pl_flit%0d_fire", f), 32'(fire), 32'h1);
            check($sformatf("pl_flit%0d_gnt", f),  32'(gnt),  32'h02);
            cyc();
        end
        check("pl_gap_gnt",    32'(gnt),        32'h0);
        check("pl_gap_locked", 32'(locked),     32'h0);
        check("pl_credit",     32'(credit_cnt), 32'h1);
        cyc();
        check("pl_gnt_p3", 32'(gnt), 32'h08);
        check("pl_sel_p3", 32'(sel), 32'h3);
        idle_inputs();

        // ---------------- credit exhaustion and same-cycle fire/return ----
        do_reset();
        cyc();
        req   = 5'b00001;
        valid = 5'b00001;
        tail  = 5'b00000;
        cyc();
        check("cr_gnt", 32'(gnt), 32'h01);
        for (int f = 0; f < 4; f++) begin
            check($sformatf("cr_flit%0d_fire", f), 32'(fire), 32'h1);
            cyc();
        end
        check("cr_empty_credit", 32'(credit_cnt), 32'h0);
        check("cr_empty_locked", 32'(locked),     32'h1);
        check("cr_empty_fire",   32'(fire),       32'h0);
        cyc();
        check("cr_stall_fire",   32'(fire),   32'h0);
        check("cr_stall_locked", 32'(locked), 32'h1);
        cred_ret = 1'b1;
        #1;
        check("cr_ret_same_cycle_fire", 32'(fire), 32'h0);
        cyc();
        check("cr_one_credit",      32'(credit_cnt), 32'h1);
        check("cr_one_credit_fire", 32'(fire),       32'h1);
        cyc();  // FIRE and CRED_RET together
        check("cr_fire_and_ret", 32'(credit_cnt), 32'h1);
        cred_ret = 1'b0;
        #1;
        check("cr_last_fire", 32'(fire), 32'h1);
        cyc();
        check("cr_drained_credit", 32'(credit_cnt), 32'h0);
        check("cr_drained_fire",   32'(fire),       32'h0);
        idle_inputs();

        // ---------------- reset in the middle of a packet -----------------
        do_reset();
        cyc();
        req   = 5'b00100;
        valid = 5'b00100;
        tail  = 5'b00000;
        cyc();
        check("mr_gnt", 32'(gnt), 32'h04);
        cyc();  // second flit on the wire
        check("mr_flit2_fire", 32'(fire), 32'h1);
        #2;
        rst_b = 1'b0;
        #1;
        check("mr_async_gnt",    32'(gnt),        32'h0);
        check("mr_async_locked", 32'(locked),     32'h0);
        check("mr_async_credit", 32'(credit_cnt), 32'h4);
        check("mr_async_fire",   32'(fire),       32'h0);
        req = 5'b01010;
        cyc();
        check("mr_held_fire", 32'(fire), 32'h0);
        rst_b = 1'b1;
        cyc();
        check("mr_rel_locked", 32'(locked), 32'h0);
        cyc();
        check("mr_regrant_gnt", 32'(gnt), 32'h02);
        check("mr_regrant_sel", 32'(sel), 32'h1);
        idle_inputs();

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_out_arbiter.md
ROUTER_OUT_ARBITER -- requirements
Module: router_out_arbiter

Interface
REQ-001 Parameter NPORT, default 5, number of requesting input ports, fixed 5 in this release.
REQ-002 Parameter CREDITS, default 4, downstream buffer depth in flits, range 1..7.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 RST_  input  1  reset, asynchronous, active-low.
REQ-005 REQ  input  5  bit i: input port i has a head flit for this output.
REQ-006 VALID  input  5  bit i: input port i presents a valid flit this cycle.
REQ-007 TAIL  input  5  bit i: the flit presented by port i is the packet tail.
REQ-008 CRED_RET  input  1  one credit returned by downstream this cycle.
REQ-009 GNT  output  5  one-hot grant, registered.
REQ-010 SEL  output  3  binary index of the granted port, for the crossbar mux; registered.
REQ-011 FIRE  output  1  a flit crosses to the output this cycle; combinational.
REQ-012 LOCKED  output  1  output is held by a packet; registered.
REQ-013 CREDIT_CNT  output  3  available downstream credits; registered.

Function
REQ-014 FSM states: IDLE and LOCK; LOCKED=1 exactly in LOCK.
REQ-015 IDLE -> LOCK when REQ!=0 and CREDIT_CNT>0; the winner is the first set REQ bit searched cyclically from (PTR+1) mod 5.
REQ-016 Grant latency is 1 cycle: GNT/SEL/LOCKED update on the edge after the IDLE cycle in which the request is seen.
REQ-017 In IDLE: GNT=0, SEL holds its last value, FIRE=0.
REQ-018 In LOCK: FIRE = VALID[SEL] & (CREDIT_CNT>0); VALID or REQ bits of non-granted ports are ignored.
REQ-019 LOCK persists until FIRE with TAIL[SEL]=1; on that edge the FSM returns to IDLE, GNT clears, and PTR <= SEL.
REQ-020 Deasserting REQ[SEL] during LOCK does not release the grant (packet lock held until tail).
REQ-021 A single-flit packet (head with TAIL=1) holds LOCK for exactly its FIRE cycle.
REQ-022 After a tail there is at least one IDLE cycle before the next grant (no back-to-back grant in the same edge).
REQ-023 The credit counter decrements on FIRE, increments on CRED_RET; both in the same cycle leave it unchanged.
REQ-024 CRED_RET when the counter is at CREDITS and FIRE=0 is ignored (saturate); FIRE never occurs at 0, so no underflow.
REQ-025 At CREDIT_CNT=0 in LOCK, the grant is held and FIRE=0 until a credit returns; a credit returned in that cycle does not enable FIRE in the same cycle.
REQ-026 Round-robin fairness: with all 5 REQ permanently set and single-flit packets, grant order is cyclic, and each port is served once per 5 grants.

Reset
REQ-027 RST_=0 asynchronously forces: state IDLE, GNT=0, SEL=0, LOCKED=0, CREDIT_CNT=CREDITS, PTR=4 (so port 0 wins first).
REQ-028 Reset asserted mid-packet abandons the lock immediately; no FIRE is produced while RST_=0.
REQ-029 Leaving reset is synchronous to clk; the first grant can occur on the second rising edge after RST_ rises.

Verification
REQ-030 Reset, then REQ=5'b00100 -> one cycle later GNT=5'b00100, SEL=2, LOCKED=1, CREDIT_CNT=4.
REQ-031 REQ=5'b11111, with 1-flit packets and VALID/TAIL always 1 -> grants in the order port 0,1,2,3,4,0, with one IDLE cycle between grants.
REQ-032 Port 1 granted, sends 3 flits (TAIL on 3rd) while port 3 requests -> port 3 is not granted until after the tail, then GNT=5'b01000.
REQ-033 CREDITS=4, no CRED_RET, 6-flit packet -> FIRE on 4 cycles, CREDIT_CNT=0, stall with LOCKED=1; one CRED_RET -> the next cycle FIRE=1 once.
REQ-034 FIRE and CRED_RET in the same cycle -> CREDIT_CNT unchanged; CRED_RET at CREDIT_CNT=4 with no FIRE -> stays 4.
REQ-035 RST_ pulsed low during LOCK on the 2nd flit -> GNT=0, LOCKED=0, CREDIT_CNT=4 asynchronously; the next request is granted to the lowest set port.
